// File: rtl/filter2d_feeder_if.sv
// Bundle of host config, upstream pixel stream and filter-facing signals for filter2d_feeder.
// The slave modport is the feeder's view; master is the host/upstream/filter side.
interface filter2d_feeder_if;
    logic       cfg_we;
    logic [3:0] cfg_idx;
    logic [7:0] cfg_data;
    logic [3:0] gap;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       o_strb;
    logic [7:0] o_data;
    logic       h_write;
    logic [3:0] h_idx;
    logic [7:0] h_data;
    logic       busy;
    logic       done;

    modport master (
        output cfg_we, cfg_idx, cfg_data, gap, start, abort, s_valid, s_data,
        input  s_ready, o_strb, o_data, h_write, h_idx, h_data, busy, done
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_data, gap, start, abort, s_valid, s_data,
        output s_ready, o_strb, o_data, h_write, h_idx, h_data, busy, done
    );
endinterface

// File: rtl/filter2d_feeder.sv
// Feeds the 2D filter: replays a host-loaded 3x3 coefficient shadow bank into the
// filter's coefficient port, then forwards one frame of pixels with a programmable gap.
module filter2d_feeder #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int N_COEF = 9
) (
    input logic              clk,
    input logic              rstn,
    filter2d_feeder_if.slave bus
);
    localparam logic [15:0] LAST_PIX = 16'(IMG_W * IMG_H - 1);
    localparam logic [3:0]  LAST_K   = 4'(N_COEF - 1);

    typedef enum logic [1:0] {IDLE, COEF, STREAM, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  coefCnt_q, coefCnt_d;
    logic [3:0]  gapCnt_q, gapCnt_d;
    logic [3:0]  gapLat_q, gapLat_d;
    logic [15:0] pixCnt_q, pixCnt_d;
    logic        strb_q, strb_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  shadow_q [N_COEF];
    logic [7:0]  shadow_d [N_COEF];
    logic [7:0]  coefVal;
    logic        readyInt;
    logic        handshake;

    assign readyInt  = (state_q == STREAM) && (gapCnt_q == 4'd0);
    assign handshake = readyInt && bus.s_valid;

    always_comb begin
        coefVal = 8'd0;
        for (int i = 0; i < N_COEF; i++) begin
            if (coefCnt_q == 4'(i)) coefVal = shadow_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        coefCnt_d = coefCnt_q;
        gapCnt_d  = gapCnt_q;
        gapLat_d  = gapLat_q;
        pixCnt_d  = pixCnt_q;
        strb_d    = 1'b0;
        data_d    = data_q;
        shadow_d  = shadow_q;

        case (state_q)
            IDLE: begin
                // A write in the start cycle lands before COEF reads the bank.
                if (bus.cfg_we && (bus.cfg_idx <= LAST_K)) begin
                    for (int i = 0; i < N_COEF; i++) begin
                        if (bus.cfg_idx == 4'(i)) shadow_d[i] = bus.cfg_data;
                    end
                end
                if (bus.start) begin
                    state_d   = COEF;
                    coefCnt_d = 4'd0;
                    gapCnt_d  = 4'd0;
                    pixCnt_d  = 16'd0;
                    gapLat_d  = bus.gap;
                end
            end
            COEF: begin
                if (coefCnt_q == LAST_K) begin
                    state_d   = STREAM;
                    coefCnt_d = 4'd0;
                end else begin
                    coefCnt_d = coefCnt_q + 4'd1;
                end
            end
            STREAM: begin
                if (handshake) begin
                    strb_d   = 1'b1;
                    data_d   = bus.s_data;
                    gapCnt_d = gapLat_q;
                    if (pixCnt_q == LAST_PIX) begin
                        state_d  = DONE;
                        pixCnt_d = 16'd0;
                    end else begin
                        pixCnt_d = pixCnt_q + 16'd1;
                    end
                end else if (gapCnt_q != 4'd0) begin
                    gapCnt_d = gapCnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort outranks start and any same-cycle handshake.
        if (bus.abort) begin
            state_d   = IDLE;
            coefCnt_d = 4'd0;
            gapCnt_d  = 4'd0;
            pixCnt_d  = 16'd0;
            strb_d    = 1'b0;
            data_d    = data_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            coefCnt_q <= 4'd0;
            gapCnt_q  <= 4'd0;
            gapLat_q  <= 4'd0;
            pixCnt_q  <= 16'd0;
            strb_q    <= 1'b0;
            data_q    <= 8'd0;
            for (int i = 0; i < N_COEF; i++) shadow_q[i] <= 8'd0;
        end else begin
            state_q   <= state_d;
            coefCnt_q <= coefCnt_d;
            gapCnt_q  <= gapCnt_d;
            gapLat_q  <= gapLat_d;
            pixCnt_q  <= pixCnt_d;
            strb_q    <= strb_d;
            data_q    <= data_d;
            shadow_q  <= shadow_d;
        end
    end

    assign bus.s_ready = readyInt;
    assign bus.o_strb  = strb_q;
    assign bus.o_data  = data_q;
    assign bus.h_write = (state_q == COEF);
    assign bus.h_idx   = (state_q == COEF) ? coefCnt_q : 4'd0;
    assign bus.h_data  = (state_q == COEF) ? coefVal : 8'd0;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_filter2d_feeder.sv
// Scoreboard bench for filter2d_feeder: the driver pushes expected coefficient writes and
// pixel strobes from a reference model; a negedge monitor pops and compares them.
module tb_filter2d_feeder;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    filter2d_feeder_if bus();

    filter2d_feeder #(.IMG_W(W), .IMG_H(H), .N_COEF(9)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct {logic [3:0] idx; logic [7:0] data;} coefExp_t;
    typedef struct {logic [7:0] data; bit last;} pixExp_t;

    coefExp_t   coefQ[$];
    pixExp_t    pixQ[$];
    logic [7:0] shadowM [9];
    int         checks = 0;
    int         passes = 0;
    int         curGap = 0;
    int         cycle = 0;
    int         lastStrobe = -1000;
    coefExp_t   ce;
    pixExp_t    pe;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every strobe or coefficient write the DUT shows must match the scoreboard head.
    always @(negedge clk) begin
        if (rstn) begin
            cycle++;
            if (bus.h_write) begin
                checkOutput("hWriteExpected", 32'(coefQ.size() != 0), 32'd1);
                checkOutput("strbDuringHWrite", 32'(bus.o_strb), 32'd0);
                if (coefQ.size() != 0) begin
                    ce = coefQ.pop_front();
                    checkOutput("hIdx", 32'(bus.h_idx), 32'(ce.idx));
                    checkOutput("hData", 32'(bus.h_data), 32'(ce.data));
                end
                lastStrobe = -1000;
            end
            if (bus.o_strb) begin
                checkOutput("strbExpected", 32'(pixQ.size() != 0), 32'd1);
                if (pixQ.size() != 0) begin
                    pe = pixQ.pop_front();
                    checkOutput("oData", 32'(bus.o_data), 32'(pe.data));
                    checkOutput("doneWithLast", 32'(bus.done), 32'(pe.last));
                end
                checkOutput("strbSpacing", 32'((cycle - lastStrobe) >= (curGap + 1)), 32'd1);
                lastStrobe = cycle;
            end
            if (bus.done) checkOutput("doneHasStrb", 32'(bus.o_strb), 32'd1);
        end
    end

    task automatic hostWrite(input logic [3:0] idx, input logic [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = idx;
        bus.cfg_data = data;
        if (idx < 4'd9) shadowM[idx] = data;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // One frame from IDLE; entered and left at a negedge.
    task automatic applyStimulus(input int g, input int validPct, input int abortAfter,
                                 input bit rstMid, input bit midPulse, input bit sameCycleWr,
                                 input bit ramp);
        int         hs = 0;
        int         since = 1000;
        int         cyc = 0;
        bit         sv;
        bit         expReady;
        bit         pulsed = 0;
        bit         timedOut = 0;
        logic [7:0] d;

        bus.gap   = 4'(g);
        bus.start = 1'b1;
        if (sameCycleWr) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_idx  = 4'd4;
            bus.cfg_data = 8'hA5;
            shadowM[4]   = 8'hA5;
        end
        curGap = g;
        for (int k = 0; k < 9; k++) coefQ.push_back('{4'(k), shadowM[k]});
        @(negedge clk);
        bus.start   = 1'b0;
        bus.cfg_we  = 1'b0;
        bus.gap     = 4'($urandom);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'($urandom);
        checkOutput("busyAfterStart", 32'(bus.busy), 32'd1);
        checkOutput("hIdxAfterStart", 32'(bus.h_idx), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            checkOutput("readyLowInCoef", 32'(bus.s_ready), 32'd0);
        end
        @(negedge clk);
        checkOutput("hWriteOffAfterLoad", 32'(bus.h_write), 32'd0);

        while (hs < NPIX && !timedOut) begin
            expReady = (since >= g);
            if (rstMid && hs == 6) begin
                #2 rstn = 1'b0;
                #1;
                checkOutput("rstOutputsClear",
                            32'({bus.s_ready, bus.o_strb, bus.h_write, bus.busy, bus.done,
                                 bus.h_idx, bus.h_data, bus.o_data}), 32'd0);
                pixQ.delete();
                coefQ.delete();
                for (int k = 0; k < 9; k++) shadowM[k] = 8'd0;
                bus.s_valid = 1'b0;
                bus.start   = 1'b0;
                bus.cfg_we  = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            checkOutput("sReady", 32'(bus.s_ready), 32'(expReady));
            if (abortAfter >= 0 && hs == abortAfter) begin
                bus.abort   = 1'b1;
                bus.s_valid = 1'b1;
                bus.s_data  = 8'h5A;
                @(negedge clk);
                bus.abort   = 1'b0;
                bus.s_valid = 1'b0;
                checkOutput("abortIdle",
                            32'({bus.busy, bus.o_strb, bus.done, bus.s_ready, bus.h_write}), 32'd0);
                repeat (4) @(negedge clk);
                checkOutput("abortNoPending", 32'(pixQ.size()), 32'd0);
                checkOutput("abortStaysIdle", 32'(bus.busy), 32'd0);
                return;
            end
            sv = ($urandom_range(99) < validPct);
            d  = ramp ? 8'(hs) : 8'($urandom);
            bus.s_valid = sv;
            bus.s_data  = d;
            if (midPulse && hs == 3 && !pulsed) begin
                bus.start    = 1'b1;
                bus.cfg_we   = 1'b1;
                bus.cfg_idx  = 4'd0;
                bus.cfg_data = ~shadowM[0];
                pulsed       = 1'b1;
            end else begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            if (sv && expReady) begin
                pixQ.push_back('{d, (hs == NPIX - 1)});
                hs++;
                since = 0;
            end else begin
                since++;
            end
            cyc++;
            if (cyc > 5000) begin
                checkOutput("frameTimeout", 32'(cyc), 32'd0);
                timedOut = 1'b1;
            end
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.start   = 1'b0;
        bus.cfg_we  = 1'b0;
        if (timedOut) return;
        checkOutput("busyInDone", 32'(bus.busy), 32'd1);
        checkOutput("readyInDone", 32'(bus.s_ready), 32'd0);
        if (g == 0 && validPct == 100) checkOutput("contiguousCycles", 32'(cyc), 32'(NPIX));
        @(negedge clk);
        checkOutput("busyFalls", 32'(bus.busy), 32'd0);
        checkOutput("doneOneCycle", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("pixQEmpty", 32'(pixQ.size()), 32'd0);
        checkOutput("coefQEmpty", 32'(coefQ.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.cfg_we   = 1'b0;
        bus.cfg_idx  = 4'd0;
        bus.cfg_data = 8'd0;
        bus.gap      = 4'd0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = 8'd0;
        for (int k = 0; k < 9; k++) shadowM[k] = 8'd0;
        #3;
        checkOutput("resetOutputs",
                    32'({bus.s_ready, bus.o_strb, bus.h_write, bus.busy, bus.done,
                         bus.h_idx, bus.h_data, bus.o_data}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("idleAfterReset",
                    32'({bus.busy, bus.s_ready, bus.h_write, bus.o_strb, bus.done}), 32'd0);

        for (int k = 0; k < 9; k++) hostWrite(4'(k), 8'(k + 1));
        hostWrite(4'd9, 8'hEE);
        hostWrite(4'd15, 8'hEF);

        applyStimulus(0, 100, -1, 0, 0, 0, 1);
        applyStimulus(2, 60, -1, 0, 1, 0, 0);
        applyStimulus(1, 80, 5, 0, 0, 0, 0);
        applyStimulus(0, 85, -1, 0, 0, 0, 0);
        applyStimulus(3, 70, -1, 0, 0, 1, 0);
        applyStimulus(2, 90, -1, 1, 0, 0, 0);
        applyStimulus(1, 100, -1, 0, 0, 0, 1);
        for (int k = 0; k < 9; k++) hostWrite(4'(k), 8'($urandom));
        applyStimulus(5, 75, -1, 0, 0, 0, 0);
        applyStimulus(0, 50, -1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
